// File: rtl/my_mem_arb_pkg.sv
// Shared types and defaults for the my_mem arbiter.
// The optional parity check is enabled with MY_MEM_ARB_PARITY_CHK_EN.
package my_mem_arb_pkg;

    localparam int unsigned AddrW  = 16;
    localparam int unsigned DataW  = 8;
    localparam int unsigned OwnerW = 3;
    localparam int unsigned CntW   = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    typedef struct packed {
        logic              we;
        logic [AddrW-1:0]  addr;
        logic [DataW-1:0]  wdata;
        logic [OwnerW-1:0] owner;
    } txn_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/my_mem_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module my_mem_rr_picker #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PtrW = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PtrW-1:0] idx_o,
    output logic            valid_o
);

    always_comb begin
        int unsigned      j;
        logic [PtrW-1:0]  jj;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        jj      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j  = (32'(ptr_i) + k) % NREQ;
            jj = PtrW'(j);
            if (!valid_o && req_i[jj]) begin
                valid_o   = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
    end

endmodule

// File: rtl/my_mem_arbiter.sv
// Round-robin arbiter sharing the single-port my_mem between NREQ requesters.
// Define MY_MEM_ARB_PARITY_CHK_EN to check even parity on reads and count errors.
module my_mem_arbiter
    import my_mem_arb_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned AW         = AddrW,
    parameter int unsigned DW         = DataW,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rvalid_o,
    output logic [DW-1:0]      rdata_o,
    output logic               perr_o,
    output logic               busy_o,
    output logic               mem_write_o,
    output logic               mem_read_o,
    output logic [AW-1:0]      mem_address_o,
    output logic [DW-1:0]      mem_data_in_o,
    input  logic [DW:0]        mem_data_out_i
);

    localparam int unsigned PtrW = $clog2(NREQ);

    state_e           state_q, state_d;
    txn_t             txn_q, txn_d;
    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]  rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             perr_q, perr_d;
    logic [NREQ-1:0]  pick_gnt;
    logic [PtrW-1:0]  pick_idx;
    logic             pick_valid;
    logic             rd_done;

    my_mem_rr_picker #(
        .NREQ (NREQ),
        .PtrW (PtrW)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign rd_done = (state_q == StWait) && (cnt_q == CntW'(1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_valid) state_d = StIssue;
            StIssue: state_d = txn_q.we ? StIdle : StWait;
            StWait:  if (rd_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // gnt is combinational so it pulses in the IDLE cycle that accepts the request.
    always_comb begin
        gnt_o       = (state_q == StIdle && rst_ni) ? pick_gnt : '0;
        busy_o      = (state_q != StIdle);
        mem_write_o = (state_q == StIssue) && txn_q.we;
        mem_read_o  = (state_q == StIssue) && !txn_q.we;
    end

    always_comb begin
        txn_d    = txn_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        perr_d   = perr_q;
        if (state_q == StIdle && pick_valid) begin
            txn_d.we    = we_i[pick_idx];
            txn_d.addr  = addr_i[pick_idx*AW +: AW];
            txn_d.wdata = wdata_i[pick_idx*DW +: DW];
            txn_d.owner = OwnerW'(pick_idx);
            ptr_d       = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
        end
        if (state_q == StIssue && !txn_q.we) begin
            cnt_d = CntW'(MEM_RD_LAT);
        end
        if (state_q == StWait) begin
            if (rd_done) begin
                rdata_d  = mem_data_out_i[DW-1:0];
                rvalid_d = NREQ'(1) << txn_q.owner;
`ifdef MY_MEM_ARB_PARITY_CHK_EN
                perr_d   = (mem_data_out_i[DW] != ^mem_data_out_i[DW-1:0]);
`else
                perr_d   = 1'b0;
`endif
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            txn_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            perr_q   <= 1'b0;
        end else begin
            txn_q    <= txn_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            perr_q   <= perr_d;
        end
    end

`ifdef MY_MEM_ARB_PARITY_CHK_EN
    logic [7:0] perr_cnt_q, perr_cnt_d;

    always_comb begin
        perr_cnt_d = perr_cnt_q;
        if (rd_done && perr_d) begin
            perr_cnt_d = sat_inc8(perr_cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perr_cnt_q <= '0;
        end else begin
            perr_cnt_q <= perr_cnt_d;
        end
    end
`else
    logic unused_parity;
    assign unused_parity = mem_data_out_i[DW];
`endif

    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign perr_o        = perr_q;
    assign mem_address_o = txn_q.addr;
    assign mem_data_in_o = txn_q.wdata;

endmodule

// File: tb/tb_my_mem_arbiter.sv
// Directed bench for my_mem_arbiter with a 1-cycle-latency my_mem model.
module tb_my_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [7:0]  rdata;
    logic        perr;
    logic        busy;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [7:0]  mem_data_in;
    logic [8:0]  mem_data_out;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    int both_hi = 0;

    logic [7:0]  mem_arr [0:65535];
    logic        corrupt_en = 1'b0;
    logic [15:0] corrupt_addr = 16'h0777;

`ifdef MY_MEM_ARB_PARITY_CHK_EN
    localparam logic PerrExp = 1'b1;
`else
    localparam logic PerrExp = 1'b0;
`endif

    always #5 clk = ~clk;

    my_mem_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .we_i           (we),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .gnt_o          (gnt),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .perr_o         (perr),
        .busy_o         (busy),
        .mem_write_o    (mem_write),
        .mem_read_o     (mem_read),
        .mem_address_o  (mem_address),
        .mem_data_in_o  (mem_data_in),
        .mem_data_out_i (mem_data_out)
    );

    // my_mem model: even parity in bit 8, optionally inverted for one address.
    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_address] <= mem_data_in;
        if (mem_read) mem_data_out <= {(^mem_arr[mem_address]) ^
                                       (corrupt_en && mem_address == corrupt_addr),
                                       mem_arr[mem_address]};
    end

    always @(negedge clk) begin
        if (mem_write) wr_pulses++;
        if (mem_write && mem_read) both_hi++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge where it is idle again.
    task automatic txn(input int r, input logic w, input logic [15:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input logic exp_perr, input string tag);
        req[r] = 1'b1;
        we[r]  = w;
        addr[r*16 +: 16] = a;
        wdata[r*8 +: 8]  = d;
        #1;
        chk({tag, "_gnt"}, 32'(gnt), 32'(1) << r);
        @(negedge clk);
        req[r] = 1'b0;
        chk({tag, "_addr"}, 32'(mem_address), 32'(a));
        if (w) begin
            chk({tag, "_wr"}, 32'(mem_write), 32'd1);
            chk({tag, "_din"}, 32'(mem_data_in), 32'(d));
            @(negedge clk);
            chk({tag, "_wr_drop"}, 32'(mem_write), 32'd0);
        end else begin
            chk({tag, "_rd"}, 32'(mem_read), 32'd1);
            @(negedge clk);
            chk({tag, "_rd_drop"}, 32'(mem_read), 32'd0);
            chk({tag, "_hold"}, 32'(mem_address), 32'(a));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            chk({tag, "_rvalid"}, 32'(rvalid), 32'(1) << r);
            chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
            chk({tag, "_perr"}, 32'(perr), 32'(exp_perr));
        end
    endtask

    logic [15:0] t_a [6] = '{16'h0000, 16'hFFFF, 16'h8001, 16'h00FF, 16'h7FFE, 16'hBEEF};
    logic [7:0]  t_d [6] = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h5A, 8'h96};
    int          order [6] = '{3, 0, 5, 1, 4, 2};

    initial begin
        rst_n = 1'b0;
        req   = 2'b11;
        we    = 2'b00;
        addr  = '0;
        wdata = '0;

        // Reset with requests pending.
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wr", 32'(mem_write), 32'd0);
        chk("rst_rd", 32'(mem_read), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        req   = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back on requester 0.
        txn(0, 1'b1, 16'h1234, 8'hA5, 8'h00, 1'b0, "t2w");
        txn(0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, "t2r");
        @(negedge clk);
        chk("t2_rvalid_pulse", 32'(rvalid), 32'd0);
        chk("t2_wr_count", 32'(wr_pulses), 32'd1);

        // Contention from a fresh pointer: grants alternate 01,10,01,10.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = 2'b11;
        we    = 2'b11;
        addr  = {16'h3000, 16'h2000};
        wdata = {8'h22, 8'h11};
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t3_gnt", 32'(gnt), (i % 2 == 1) ? 32'd0 : ((i % 4 == 0) ? 32'd1 : 32'd2));
            @(negedge clk);
        end
        req = 2'b00;
        @(negedge clk);

        // Scattered writes from both requesters, reads in shuffled order.
        for (int i = 0; i < 6; i++) begin
            txn(i % 2, 1'b1, t_a[i], t_d[i], 8'h00, 1'b0, "t4w");
        end
        for (int i = 0; i < 6; i++) begin
            txn((order[i] + 1) % 2, 1'b0, t_a[order[i]], 8'h00, t_d[order[i]], 1'b0, "t4r");
        end

        // Reset while waiting for read data.
        req[0] = 1'b1;
        we[0]  = 1'b0;
        addr[15:0] = 16'h0042;
        #1;
        chk("t5_gnt", 32'(gnt), 32'd1);
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        chk("t5_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rvalid_a", 32'(rvalid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rvalid_b", 32'(rvalid), 32'd0);
        req = 2'b11;
        we  = 2'b11;
        #1;
        chk("t5_next_gnt", 32'(gnt), 32'd1);
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);

        // Corrupted parity on read data.
        corrupt_en = 1'b1;
        txn(1, 1'b1, 16'h0777, 8'hA5, 8'h00, 1'b0, "t6w");
        txn(1, 1'b0, 16'h0777, 8'h00, 8'hA5, PerrExp, "t6r");
`ifdef MY_MEM_ARB_PARITY_CHK_EN
        chk("t6_perr_cnt", 32'(dut.perr_cnt_q), 32'd1);
`endif
        @(negedge clk);

        chk("no_dual_strobe", 32'(both_hi), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
